hsc_save_io: RTL
================

# hsc_save_io

Bridges the High Score Cart save RAM to the HPS file-transfer channel for persistence. Sits between hps_io and port B of the dual-port HSC NVRAM, beside the cart loader. Serves upload (NVRAM → HPS, i.e. save) read requests and download (HPS → NVRAM, i.e. restore) write strobes. Also tracks a dirty flag from core-side writes so the OSD can offer or trigger saving.

## Interface

Parameters:
- ADDR_W, 11: NVRAM address width; save image is 2^ADDR_W bytes (2048).
- SAVE_INDEX, 8'd2: ioctl_index value that selects this block.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  HPS upload (save) transfer active.
- ioctl_download  in  1  HPS download (restore) transfer active.
- ioctl_index  in  8  transfer target; block responds only when equal to SAVE_INDEX.
- ioctl_addr  in  25  byte address of current transfer beat.
- ioctl_rd  in  1  one-cycle read request during upload.
- ioctl_wr  in  1  one-cycle write strobe during download.
- ioctl_dout  in  8  download data byte.
- ioctl_din  out  8  upload data byte; valid when ioctl_wait is low after a read request.
- ioctl_wait  out  1  stall to hps_io while a read is in flight.
- ram_addr  out  ADDR_W  NVRAM port-B address.
- ram_we  out  1  NVRAM port-B write enable.
- ram_wdata  out  8  NVRAM port-B write data.
- ram_rdata  in  8  NVRAM port-B read data, registered, 1-cycle latency after ram_addr.
- core_we  in  1  core-side NVRAM write strobe, used only for dirty tracking.
- save_dirty  out  1  NVRAM modified since last complete upload or download.
- busy  out  1  high while a selected transfer is active.

## Operation

- sel = (ioctl_index == SAVE_INDEX). An upload is active when ioctl_upload & sel; a download is active when ioctl_download & sel.
- The FSM has four states: IDLE, RD_ADDR, RD_WAIT, RD_DONE.
  - IDLE:
    - On ioctl_rd during an active upload, with ioctl_addr < 2^ADDR_W: drive ram_addr = ioctl_addr[ADDR_W-1:0], assert ioctl_wait, and go to RD_ADDR.
    - On ioctl_rd with ioctl_addr ≥ 2^ADDR_W: set ioctl_din = 8'hFF next cycle with no stall, and stay in IDLE.
  - RD_ADDR: go to RD_WAIT, which covers RAM latency.
  - RD_WAIT: latch ioctl_din <= ram_rdata, increment the upload byte counter, and go to RD_DONE.
  - RD_DONE: deassert ioctl_wait and return to IDLE.
- Download write path (combinational pass-through, IDLE only): when ioctl_wr occurs during an active download with ioctl_addr < 2^ADDR_W:
  - ram_we = 1, ram_addr = ioctl_addr[ADDR_W-1:0], ram_wdata = ioctl_dout.
  - Increment the download byte counter.
- Out-of-range writes are dropped.
- Byte counters are ADDR_W+1 bits wide. They saturate at 2^ADDR_W and are cleared on the rising edge of the corresponding selected transfer.
- Dirty tracking:
  - core_we sets save_dirty.
  - The falling edge of a selected upload or download clears save_dirty, but only if its counter equals 2^ADDR_W.
  - If core_we and a clear occur in the same cycle, set wins (save_dirty stays 1).
- Transfers not matching SAVE_INDEX are ignored entirely: no RAM access, no stall, no counter or dirty change.
- If ioctl_rd arrives while not in IDLE, it is ignored; hps_io must not issue reads while ioctl_wait is high.
- ioctl_wr during an upload is ignored, and ioctl_rd during a download is ignored.

## Timing

- Reset values: state IDLE, ioctl_din 8'h00, ioctl_wait 0, ram_we 0, ram_addr 0, ram_wdata 0, save_dirty 0, busy 0, both counters 0, edge registers 0.
- Read latency: ioctl_rd at cycle N leads to ioctl_wait high from N+1 through N+3. ioctl_din is valid from N+3 and holds until the next read.
- Out-of-range read: ioctl_din = FF at N+1, and ioctl_wait is never asserted.
- Write: ram_we is asserted in the same cycle as ioctl_wr (zero latency) and never more than one cycle per strobe.
- busy tracks the selected ioctl_upload or ioctl_download with one-cycle registered delay.
- save_dirty updates one cycle after core_we or after the transfer's falling edge.
- Reset mid-read forces IDLE, deasserts ioctl_wait the next cycle, and clears the counters and dirty flag; the in-flight byte is lost.
- Transfer end mid-read (ioctl_upload falls before RD_DONE): the FSM completes its remaining states, and dirty evaluation uses the counter value at the falling edge.

## Test plan

- Preload NVRAM[i] = i^8'h5A; full upload with index 2, addr 0..2047 → each ioctl_din equals addr[7:0]^8'h5A, ioctl_wait high exactly 3 cycles per read, save_dirty 1→0 at end.
- Upload with ioctl_rd at addr 2048 and 4000 → ioctl_din = FF one cycle later, ioctl_wait stays 0.
- Full download of 2048 bytes of 8'hC3 → NVRAM reads back all C3; ram_we pulses 2048 times; save_dirty cleared.
- Partial upload (1000 bytes) after core_we → save_dirty remains 1.
- core_we asserted in the same cycle as the clearing upload falling edge → save_dirty = 1.
- Transfer with ioctl_index = 1 (cart) including 10 writes → no ram_we, no ioctl_wait, busy 0. Separately, assert reset during RD_WAIT → ioctl_wait = 0 and state IDLE next cycle.

Source files
------------

// File: rtl/hsc_save_io.sv
// rtl/hsc_save_io.sv - HSC NVRAM save/restore bridge between hps_io and NVRAM port B
// Serves upload reads through a 3-cycle stall and passes download writes straight through.
module hsc_save_io #(
    parameter int          ADDR_W     = 11,
    parameter logic [7:0]  SAVE_INDEX = 8'd2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              core_we,
    output logic              save_dirty,
    output logic              busy
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_ADDR = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic              busy_q, busy_d;
    logic              dirty_q, dirty_d;
    logic [ADDR_W:0]   up_cnt_q, up_cnt_d;
    logic [ADDR_W:0]   dn_cnt_q, dn_cnt_d;

    logic sel, up_act, dn_act, in_range, is_idle;
    logic rd_go, rd_oor, wr_go, up_fall, dn_fall, dirty_clr;

    always_comb begin
        sel      = (ioctl_index == SAVE_INDEX);
        up_act   = ioctl_upload & sel;
        dn_act   = ioctl_download & sel;
        in_range = (ioctl_addr[24:ADDR_W] == '0);
        is_idle  = (state_q == S_IDLE);
        rd_go    = is_idle & up_act & ~dn_act & ioctl_rd & in_range;
        rd_oor   = is_idle & up_act & ~dn_act & ioctl_rd & ~in_range;
        // Write strobe is a pure pass-through so the RAM sees it in the same cycle.
        wr_go    = is_idle & dn_act & ~up_act & ioctl_wr & in_range & ~reset;
        up_fall  = ~up_act & up_q;
        dn_fall  = ~dn_act & dn_q;
    end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (rd_go) begin
                    state_d = S_RD_ADDR;
                    addr_d  = ioctl_addr[ADDR_W-1:0];
                end else if (rd_oor) begin
                    din_d = 8'hFF;
                end
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                din_d   = ram_rdata;
                state_d = S_RD_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        wait_d = (state_d != S_IDLE);
    end

    always_comb begin
        up_d   = up_act;
        dn_d   = dn_act;
        busy_d = up_act | dn_act;

        up_cnt_d = (up_act & ~up_q) ? '0 : up_cnt_q;
        if (state_q == S_RD_WAIT && up_cnt_d != CNT_FULL)
            up_cnt_d = up_cnt_d + CNT_ONE;

        dn_cnt_d = (dn_act & ~dn_q) ? '0 : dn_cnt_q;
        if (wr_go && dn_cnt_d != CNT_FULL)
            dn_cnt_d = dn_cnt_d + CNT_ONE;

        // Only a transfer that covered the whole image counts as a saved copy.
        dirty_clr = (up_fall & (up_cnt_q == CNT_FULL)) | (dn_fall & (dn_cnt_q == CNT_FULL));
        dirty_d   = core_we | (dirty_q & ~dirty_clr);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            addr_q   <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            busy_q   <= 1'b0;
            dirty_q  <= 1'b0;
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            busy_q   <= busy_d;
            dirty_q  <= dirty_d;
            up_cnt_q <= up_cnt_d;
            dn_cnt_q <= dn_cnt_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_we     = wr_go;
    assign ram_wdata  = wr_go ? ioctl_dout : 8'h00;
    assign ram_addr   = (wr_go | rd_go) ? ioctl_addr[ADDR_W-1:0] : addr_q;
    assign save_dirty = dirty_q;
    assign busy       = busy_q;
endmodule
